// File: rtl/uart_pkg.sv
// Shared UART definitions: parity codes, transmit FSM states, frame limits
// and the parity helper used when a character is accepted.
package uart_pkg;

  // Longest frame: start + 8 data + parity + 2 stop.
  localparam int UART_MAX_FRAME_BITS = 12;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_ODD  = 2'b01,
    PAR_EVEN = 2'b10,
    PAR_MARK = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Parity bit for the character. In 7-bit mode bit 7 does not contribute.
  function automatic logic calc_parity(input logic [7:0] data,
                                       input logic       len8,
                                       input parity_t    ptype);
    logic ones_odd;
    logic par;
    ones_odd = len8 ? ^data : ^data[6:0];
    par      = 1'b0;
    case (ptype)
      PAR_ODD:  par = ~ones_odd;
      PAR_EVEN: par = ones_odd;
      PAR_MARK: par = 1'b1;
      default:  par = 1'b0;
    endcase
    return par;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side character handshake and framing configuration for uart_tx_ctrl.
//   tx_valid    : host requests transmission of data_in
//   tx_ready    : controller idle and able to accept a character
//   data_in     : character (bit 7 unused in 7-bit mode)
//   parity_type : 00 none, 01 odd, 10 even, 11 mark
//   stop_bits   : 0 = one stop bit, 1 = two
//   data_length : 1 = 8 data bits, 0 = 7
interface uart_tx_ctrl_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;

  modport master (
    output tx_valid, data_in, parity_type, stop_bits, data_length,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, data_in, parity_type, stop_bits, data_length,
    output tx_ready
  );
endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   clk, rst : clock, asynchronous active-high reset
//   start    : restart the period from zero
//   en       : count while high; held at zero otherwise
//   bit_end  : one-cycle strobe in the last cycle of each CLKS_PER_BIT period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic en,
  output logic bit_end
);

  localparam int CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = cnt_q;
    bit_end = 1'b0;
    if (start || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LastCnt) begin
      cnt_d   = '0;
      bit_end = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller. Accepts one character over the host handshake,
// latches it with its framing configuration and serialises
// start / data (LSB first) / optional parity / stop bits onto tx.
//   clk, rst   : clock, asynchronous active-high reset
//   host       : handshake + configuration (slave side)
//   tx         : serial line, idles high
//   busy       : frame in progress
//   done       : one-cycle pulse after the last stop bit
//   parity_out : parity bit of the last accepted frame (0 with no parity)
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_ctrl_if.slave   host,
  output logic            tx,
  output logic            busy,
  output logic            done,
  output logic            parity_out
);

  localparam int IdxW = $clog2(UART_MAX_FRAME_BITS);

  tx_state_t       state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [IdxW-1:0] idx_q, idx_d;
  parity_t         ptype_q, ptype_d;
  logic            stop2_q, stop2_d;
  logic            len8_q, len8_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic accept;
  logic bit_end;

  assign accept        = host.tx_valid && (state_q == IDLE);
  assign host.tx_ready = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign tx            = tx_q;
  assign done          = done_q;
  assign parity_out    = par_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .en      (busy),
    .bit_end (bit_end)
  );

  // tx is registered and loaded with the next bit on the edge that changes
  // state, so the line level and the state always switch together.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    ptype_d = ptype_q;
    stop2_d = stop2_q;
    len8_d  = len8_q;
    par_d   = par_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          ptype_d = parity_t'(host.parity_type);
          stop2_d = host.stop_bits;
          len8_d  = host.data_length;
          par_d   = calc_parity(host.data_in, host.data_length,
                                parity_t'(host.parity_type));
          shift_d = host.data_length ? host.data_in : {1'b0, host.data_in[6:0]};
          idx_d   = '0;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          idx_d   = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (idx_q == (len8_q ? IdxW'(7) : IdxW'(6))) begin
            idx_d = '0;
            if (ptype_q != PAR_NONE) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            idx_d   = idx_q + IdxW'(1);
          end
        end
      end

      PARITY: begin
        if (bit_end) begin
          tx_d    = 1'b1;
          idx_d   = '0;
          state_d = STOP;
        end
      end

      STOP: begin
        if (bit_end) begin
          tx_d = 1'b1;
          if (stop2_q && (idx_q == '0)) begin
            idx_d = IdxW'(1);
          end else begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      ptype_q <= PAR_NONE;
      stop2_q <= 1'b0;
      len8_q  <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      ptype_q <= ptype_d;
      stop2_q <= stop2_d;
      len8_q  <= len8_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that accepts one character at a time over a valid/ready handshake. It latches the character together with its framing configuration (parity type, stop bits, data length) and serialises the resulting frame LSB-first onto the `tx` line at a fixed bit period. It sits between the host-side byte source and the UART pin. It owns frame sequencing, bit timing and parity generation for the transmit path.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_valid`  in  1  request to send `data_in` with the current config.
- `tx_ready`  out  1  controller can accept a character (high only in IDLE).
- `data_in`  in  8  character; bit 7 ignored in 7-bit mode.
- `parity_type`  in  2  00 none, 01 odd, 10 even, 11 mark (parity bit = 1).
- `stop_bits`  in  1  0 = one stop bit, 1 = two stop bits.
- `data_length`  in  1  1 = 8 data bits, 0 = 7 data bits.
- `tx`  out  1  serial line; idles high.
- `busy`  out  1  frame in progress (any state except IDLE).
- `done`  out  1  one-cycle pulse at frame completion.
- `parity_out`  out  1  parity bit of the last accepted frame; 0 when parity_type = 00.

## Operation

- States: IDLE → START → DATA → PARITY (skipped when parity_type = 00) → STOP → IDLE.
- Acceptance occurs on the edge where `tx_valid && tx_ready`. On that edge the controller latches `data_in`, `parity_type`, `stop_bits`, `data_length` and the computed parity. Input changes while busy are ignored.
- Parity is computed over `data_in[6:0]` or `data_in[7:0]`:
  - odd: total ones in data + parity bit is odd.
  - even: total ones in data + parity bit is even.
  - mark: parity bit is 1.
- Bit order: start (0), data LSB first (7 or 8 bits), optional parity, then 1 or 2 stop bits (1).
- Frame bit count N = 1 + (7|8) + (0|1) + (1|2), range 9..12.
- Each bit is held exactly `CLKS_PER_BIT` cycles, timed by a bit-period counter and a bit index counter.
- `tx_ready` = (state == IDLE). `busy` = !tx_ready.
- Reset values: `tx` = 1, `tx_ready` = 1, `busy` = 0, `done` = 0, `parity_out` = 0, state = IDLE, all counters 0.

## Timing

- Let the acceptance edge be cycle 0.
- `tx` = 0 during cycles 1..CLKS_PER_BIT.
- Bit k (k = 0..N-1) is driven during cycles k·CLKS_PER_BIT+1 .. (k+1)·CLKS_PER_BIT.
- `parity_out` updates in cycle 1 and holds until the next acceptance.
- Cycle N·CLKS_PER_BIT+1: state = IDLE, `done` = 1 for this cycle only, `tx_ready` = 1, `tx` = 1.
- Back-to-back: a request accepted in the `done` cycle starts its start bit one cycle later. The guaranteed inter-frame idle is exactly one cycle beyond the stop bits.
- Reset mid-frame: `tx` goes to 1 immediately (asynchronously), the frame is abandoned, no `done` pulse is produced, and `tx_ready` = 1 after reset release.
- `tx_valid` asserted during reset is ignored. The first acceptance is possible on the first edge after `rst` falls.

## Structure

- Shared package `uart_pkg` holds:
  - parity codes `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`, `PAR_MARK`;
  - the state enum `tx_state_t`;
  - `UART_MAX_FRAME_BITS = 12`.
- One sub-module, `uart_bit_timer`:
  - counts `CLKS_PER_BIT` cycles;
  - emits a one-cycle `bit_end` strobe;
  - restarts on a `start` input;
  - counter width is $clog2(CLKS_PER_BIT).
- The FSM, shift register, bit index and parity logic live in `uart_tx_ctrl`.

## Test plan

All tests use CLKS_PER_BIT = 16.

- 8N1, data 0xAA → `tx` bits 0, 0,1,0,1,0,1,0,1, 1, each held 16 cycles; `done` in cycle 161; `parity_out` = 0.
- 7O2, data 0x66 → data bits 0,1,1,0,0,1,1, parity 1, stop 1,1 (N = 11); `done` in cycle 177; `parity_out` = 1.
- 8E1, data 0x69 → parity bit 0 (N = 11); `done` in cycle 177. Change `data_in` to 0xFF mid-frame → serialised bits unchanged.
- Mark parity, 2 stop bits, 8-bit, data 0xF0 → parity bit 1 (N = 12); `done` in cycle 193.
- Hold `tx_valid` high with 0x55 then 0x0F in 8N1 → second acceptance in cycle 161, second start bit in cycles 162..177; two `done` pulses total.
- Assert `rst` during data bit 3 → `tx` = 1 and `busy` = 0 in the same cycle; no `done` pulse; `tx_ready` = 1 after release; a new 8N1 frame afterwards is correct.
